instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have parameter DEPTH, default 4, setting the instruction buffer entries; legal values are powers of 2 from 2 to 16.
REQ-003 Port: clk  in  1  clock; all state updates on the rising edge.
REQ-004 Port: rst_n  in  1  reset; one clock, reset synchronous and active-low.
REQ-005 Port: imem_req_valid  out  1  fetch request valid.
REQ-006 Port: imem_req_ready  in  1  memory accepts the request.
REQ-007 Port: imem_req_addr  out  32  word-aligned fetch address.
REQ-008 Port: imem_rsp_valid  in  1  response valid; responses return in request order with 1 or more cycles latency.
REQ-009 Port: imem_rsp_data  in  32  instruction word.
REQ-010 Port: redirect_valid  in  1  branch/jump/jalr redirect strobe.
REQ-011 Port: redirect_pc  in  32  redirect target; bits [1:0] ignored.
REQ-012 Port: instr_valid  out  1  buffered instruction available to decode.
REQ-013 Port: instr_ready  in  1  decode consumes the instruction.
REQ-014 Port: instr  out  32  instruction word; instr[6:0] is the opcode field for the decoder.
REQ-015 Port: instr_pc  out  32  address of instr.
REQ-016 Port: fetch_count  out  32  count of instructions delivered (see Configuration).

Function
REQ-017 A request SHALL be accepted on a cycle with imem_req_valid and imem_req_ready both high; fetch_pc SHALL then advance by 4 with 32-bit wrap-around (32'hFFFF_FFFC to 0).
REQ-018 imem_req_valid SHALL be high only in FETCH state, and only when outstanding + occupancy < DEPTH; no buffer overflow is allowed.
REQ-019 Each imem_rsp_valid in FETCH SHALL push {data, pc} into a FIFO; the pc comes from an in-order tag queue of issued addresses.
REQ-020 The FIFO head SHALL drive instr and instr_pc; instr_valid = (occupancy != 0); the head pops when instr_valid and instr_ready are both high.
REQ-021 A response SHALL reach instr_valid on the cycle after imem_rsp_valid (1-cycle latency); there is no combinational bypass.
REQ-022 A simultaneous push and pop SHALL leave occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 The FSM SHALL have states RESET_WAIT, FETCH and DRAIN.
REQ-024 RESET_WAIT SHALL move to FETCH one cycle after rst_n deasserts.
REQ-025 In FETCH, redirect_valid SHALL set fetch_pc to {redirect_pc[31:2], 2'b00} and flush the FIFO the same edge; it SHALL enter DRAIN if outstanding > 0, otherwise stay in FETCH.
REQ-026 In DRAIN, imem_req_valid SHALL be 0; each response SHALL be discarded and decrement outstanding; the FSM SHALL return to FETCH when the count reaches 0.
REQ-027 On redirect, a request handshaking in the same cycle SHALL count as stale; a response arriving in the same cycle SHALL be discarded.
REQ-028 A redirect in DRAIN SHALL update fetch_pc and remain in DRAIN.
REQ-029 Redirect SHALL take priority over pop; instr_valid SHALL be 0 the cycle after a redirect.

Reset
REQ-030 With rst_n low at a clock edge: fetch_pc = RESET_PC, FIFO empty, outstanding = 0, state = RESET_WAIT.
REQ-031 Reset outputs SHALL be imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, fetch_count=0, and imem_req_addr=RESET_PC.
REQ-032 Reset mid-operation SHALL abandon all in-flight requests; responses arriving during reset or RESET_WAIT SHALL be ignored.

Configuration
REQ-033 With macro IFETCH_STATS_EN defined, fetch_count SHALL increment (wrapping) on every pop and clear on reset or redirect; without it, fetch_count SHALL be constant 0 and no counter is built.

Verification
REQ-034 Reset with RESET_PC=32'h100, imem_req_ready=1, 1-cycle memory -> addresses 0x100, 0x104, 0x108; instr_pc values match in order.
REQ-035 instr_ready=0, DEPTH=4 -> exactly 4 requests, then imem_req_valid stays 0; releasing instr_ready resumes fetch.
REQ-036 Memory latency 3, redirect to 0x2002 with 2 requests outstanding -> DRAIN discards 2 responses; next request is 0x2000; no stale instr_valid.
REQ-037 fetch_pc=32'hFFFF_FFFC -> next request address is 0x0000_0000.
REQ-038 Assert rst_n=0 mid-stream with responses pending -> all outputs at reset values next cycle; late responses never appear on instr.
REQ-039 With IFETCH_STATS_EN, 5 pops -> fetch_count=5, then redirect -> 0; without it, fetch_count is always 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch: in-order request issue, response tag queue, decode FIFO.
// IFETCH_STATS_EN builds a delivered-instruction counter on fetch_count.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] fetch_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int IW = CW + 1;

  typedef enum logic [1:0] {
    RESET_WAIT,
    FETCH,
    DRAIN
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   tag_pc    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] tag_wr;
  logic [PW-1:0] tag_rd;
  logic [CW-1:0] occ;
  logic [CW-1:0] outst;
  logic [CW-1:0] outst_nxt;
  logic [IW-1:0] inflight;
  logic          accept;
  logic          rsp_take;
  logic          redir;
  logic          push;
  logic          pop;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Room is reserved for every in-flight request so responses never overflow.
  assign inflight = {1'b0, outst} + {1'b0, occ};
  assign imem_req_valid = (state == FETCH) &&
                          (inflight < IW'(DEPTH));
  assign imem_req_addr = fetch_pc;

  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && (outst != '0) &&
                    (state != RESET_WAIT);
  assign redir    = redirect_valid && (state != RESET_WAIT);
  assign push     = rsp_take && (state == FETCH) && !redir;
  assign pop      = instr_valid && instr_ready && !redir;

  assign outst_nxt = outst + CW'(accept) - CW'(rsp_take);

  assign instr_valid = (occ != '0);
  assign instr       = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (accept)
      tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= tag_pc[tag_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RESET_WAIT;
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      occ      <= '0;
      outst    <= '0;
    end else begin
      outst <= outst_nxt;
      if (accept)
        tag_wr <= tag_wr + PW'(1);
      if (rsp_take)
        tag_rd <= tag_rd + PW'(1);
      if (redir)
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (accept)
        fetch_pc <= fetch_pc + 32'd4;
      if (redir) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
      unique case (state)
        RESET_WAIT: state <= FETCH;
        FETCH: begin
          if (redir && (outst_nxt != '0))
            state <= DRAIN;
        end
        DRAIN: begin
          if (outst_nxt == '0)
            state <= FETCH;
        end
        default: state <= RESET_WAIT;
      endcase
    end
  end

`ifdef IFETCH_STATS_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (redir)
      cnt <= '0;
    else if (pop)
      cnt <= cnt + 32'd1;
  end

  assign fetch_count = cnt;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table plus latency/reset/stats sequences.
// Memory model returns addr ^ 32'h5A5A_0013 after a programmable latency.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] fetch_count;

  instr_fetch #(
    .RESET_PC(32'h0000_0100),
    .DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fetch_count   (fetch_count)
  );

`ifdef IFETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] ecnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (imem_req_valid && imem_req_ready)
      mq.push_back('{addr: imem_req_addr, due: cyc + lat});
  end

  always @(negedge clk) begin
    if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " rv"}, 32'(imem_req_valid), 32'd0);
    chk({nm, " addr"}, imem_req_addr, 32'h100);
    chk({nm, " iv"}, 32'(instr_valid), 32'd0);
    chk({nm, " instr"}, instr, 32'd0);
    chk({nm, " ipc"}, instr_pc, 32'd0);
    chk({nm, " cnt"}, fetch_count, 32'd0);
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        irdy;
    logic        rd;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;

  function automatic vec_t mk(input logic rdy, irdy, rd,
                              input logic [31:0] rpc,
                              input logic rv,
                              input logic [31:0] addr,
                              input logic iv,
                              input logic [31:0] ipc);
    vec_t v;
    v.rst  = 1'b1;
    v.rdy  = rdy;
    v.irdy = irdy;
    v.rd   = rd;
    v.rpc  = rpc;
    v.rv   = rv;
    v.addr = addr;
    v.iv   = iv;
    v.ipc  = ipc;
    return v;
  endfunction

  vec_t tbl[21];

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int n;
    string nm;

    tbl[0]  = mk(1, 1, 0, 0,            0, 32'h100,      0, 0);
    tbl[1]  = mk(1, 1, 0, 0,            1, 32'h100,      0, 0);
    tbl[2]  = mk(1, 1, 0, 0,            1, 32'h104,      0, 0);
    tbl[3]  = mk(1, 1, 0, 0,            1, 32'h108,      1, 32'h100);
    tbl[4]  = mk(1, 0, 0, 0,            1, 32'h10C,      1, 32'h104);
    tbl[5]  = mk(1, 0, 0, 0,            1, 32'h110,      1, 32'h104);
    tbl[6]  = mk(1, 0, 0, 0,            0, 32'h114,      1, 32'h104);
    tbl[7]  = mk(1, 0, 0, 0,            0, 32'h114,      1, 32'h104);
    tbl[8]  = mk(1, 1, 0, 0,            0, 32'h114,      1, 32'h104);
    tbl[9]  = mk(1, 1, 0, 0,            1, 32'h114,      1, 32'h108);
    tbl[10] = mk(1, 1, 1, 32'h2002,     1, 32'h118,      1, 32'h10C);
    tbl[11] = mk(1, 1, 0, 0,            0, 32'h2000,     0, 0);
    tbl[12] = mk(1, 1, 0, 0,            1, 32'h2000,     0, 0);
    tbl[13] = mk(1, 1, 0, 0,            1, 32'h2004,     0, 0);
    tbl[14] = mk(1, 1, 1, 32'hFFFF_FFFC, 1, 32'h2008,    1, 32'h2000);
    tbl[15] = mk(1, 1, 0, 0,            0, 32'hFFFF_FFFC, 0, 0);
    tbl[16] = mk(1, 1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0);
    tbl[17] = mk(1, 1, 0, 0,            1, 32'h0,        0, 0);
    tbl[18] = mk(0, 1, 0, 0,            1, 32'h4,        1, 32'hFFFF_FFFC);
    tbl[19] = mk(0, 0, 1, 32'h300,      1, 32'h4,        1, 32'h0);
    tbl[20] = mk(0, 1, 0, 0,            1, 32'h300,      0, 0);

    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    @(posedge clk);
    @(posedge clk);
    step();
    chk_reset("reset");

    cnt = 0;
    for (int i = 0; i < 21; i++) begin
      nm = $sformatf("row%0d", i);
      chk({nm, " rv"}, 32'(imem_req_valid), 32'(tbl[i].rv));
      chk({nm, " addr"}, imem_req_addr, tbl[i].addr);
      chk({nm, " iv"}, 32'(instr_valid), 32'(tbl[i].iv));
      chk({nm, " ipc"}, instr_pc, tbl[i].ipc);
      chk({nm, " instr"}, instr,
          tbl[i].iv ? mdata(tbl[i].ipc) : 32'd0);
      chk({nm, " cnt"}, fetch_count, ecnt(cnt));
      rst_n          = tbl[i].rst;
      imem_req_ready = tbl[i].rdy;
      instr_ready    = tbl[i].irdy;
      redirect_valid = tbl[i].rd;
      redirect_pc    = tbl[i].rpc;
      if (tbl[i].rd)
        cnt = 0;
      else if (tbl[i].iv && tbl[i].irdy)
        cnt++;
      step();
    end

    // Latency 3, redirect with two requests outstanding
    lat = 3;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    step();
    chk("lat3 a1", imem_req_addr, 32'h304);
    step();
    chk("lat3 a2", imem_req_addr, 32'h308);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2002;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    chk("drain0 rv", 32'(imem_req_valid), 32'd0);
    chk("drain0 iv", 32'(instr_valid), 32'd0);
    chk("drain0 addr", imem_req_addr, 32'h2000);
    chk("drain0 cnt", fetch_count, 32'd0);
    step();
    chk("drain1 rv", 32'(imem_req_valid), 32'd0);
    chk("drain1 iv", 32'(instr_valid), 32'd0);
    step();
    chk("resume rv", 32'(imem_req_valid), 32'd1);
    chk("resume addr", imem_req_addr, 32'h2000);
    chk("resume iv", 32'(instr_valid), 32'd0);
    step();
    imem_req_ready = 1'b0;
    n = 0;
    while (!instr_valid && n < 10) begin
      step();
      n++;
    end
    chk("lat3 latency", 32'(n), 32'd3);
    chk("lat3 ipc", instr_pc, 32'h2000);
    chk("lat3 instr", instr, mdata(32'h2000));

    // Reset while responses are in flight
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    step();
    step();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    step();
    chk_reset("midrst");
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("inrst%0d iv", k), 32'(instr_valid), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("postrst%0d iv", k), 32'(instr_valid), 32'd0);
    end
    chk("postrst rv", 32'(imem_req_valid), 32'd1);
    chk("postrst addr", imem_req_addr, 32'h100);
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    step();
    imem_req_ready = 1'b0;
    n = 0;
    while (!instr_valid && n < 10) begin
      step();
      n++;
    end
    chk("postrst wait", 32'(n < 10), 32'd1);
    chk("postrst ipc", instr_pc, 32'h100);
    step();

    // Fill the buffer, then drain four more: five pops since reset
    lat = 1;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    repeat (8) step();
    chk("full rv", 32'(imem_req_valid), 32'd0);
    chk("full cnt", fetch_count, ecnt(1));
    imem_req_ready = 1'b0;
    instr_ready    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pop%0d iv", k), 32'(instr_valid), 32'd1);
      chk($sformatf("pop%0d ipc", k), instr_pc, 32'h104 + 32'(4 * k));
      step();
    end
    chk("empty iv", 32'(instr_valid), 32'd0);
    chk("stats cnt5", fetch_count, ecnt(5));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    chk("stats redir cnt", fetch_count, 32'd0);
    chk("stats redir addr", imem_req_addr, 32'h40);
    chk("stats redir iv", 32'(instr_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
